// File: rtl/vec_regfile_pkg.sv
// Shared types and helpers for the multi-ported vector register file.
// Defines the clear/idle state type, default geometry and the byte-lane merge used for writes and bypass.
package vec_regfile_pkg;

  typedef enum logic [0:0] {
    VRF_CLEAR = 1'b0,
    VRF_IDLE  = 1'b1
  } vrf_state_t;

  localparam int VRF_DATA_WIDTH = 128;
  localparam int VRF_ADDR_WIDTH = 5;

  // One byte lane: take the new byte when its enable is set, otherwise keep the old one.
  function automatic logic [7:0] byte_merge(
    input logic [7:0] old_byte,
    input logic [7:0] new_byte,
    input logic       be
  );
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/vec_regfile_mp_read_port.sv
// One registered read port. The same-cycle write is folded in byte-by-byte so a
// read of the address being written returns the post-write value (write-first).
module vrf_read_port
  import vec_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = VRF_DATA_WIDTH,
  parameter int ADDR_WIDTH = VRF_ADDR_WIDTH,
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_fire,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_word,
  input  logic                  wr_fire,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  logic                  bypass_hit;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic                  rd_valid_reg;

  assign bypass_hit = wr_fire && (wr_addr == rd_addr);

  for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
    assign rd_word[8*gi +: 8] = bypass_hit
                              ? byte_merge(mem_word[8*gi +: 8], wr_data[8*gi +: 8], wr_be[gi])
                              : mem_word[8*gi +: 8];
  end

  // Data only moves on an accepted read; otherwise the last value is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_fire;
      if (rd_fire) begin
        rd_data_reg <= rd_word;
      end
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: rtl/vec_regfile_mp.sv
// Vector register file: one byte-enabled write port, two independent registered read ports,
// and a clear engine that zeroes every register after reset while holding off all requests.
module vec_regfile_mp
  import vec_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = VRF_DATA_WIDTH,
  parameter int ADDR_WIDTH = VRF_ADDR_WIDTH,
  localparam int DEPTH     = 2 ** ADDR_WIDTH,
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic                  rd_valid_a,
  input  logic                  rd_en_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  rd_valid_b,
  output logic                  busy
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  vrf_state_t            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr_reg, clr_ptr_next;
  logic                  busy_reg, busy_next;
  logic                  clr_we;
  logic                  idle;
  logic                  wr_fire;
  logic                  rd_fire_a, rd_fire_b;
  logic [DATA_WIDTH-1:0] mem_word_a, mem_word_b;

  assign idle      = (state_reg == VRF_IDLE);
  assign wr_fire   = wr_en   && idle;
  assign rd_fire_a = rd_en_a && idle;
  assign rd_fire_b = rd_en_b && idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= VRF_CLEAR;
      clr_ptr_reg <= '0;
      busy_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    busy_next    = busy_reg;
    clr_we       = 1'b0;
    case (state_reg)
      VRF_CLEAR: begin
        clr_we       = 1'b1;
        clr_ptr_next = clr_ptr_reg + ADDR_WIDTH'(1);
        if (clr_ptr_reg == ADDR_WIDTH'(DEPTH - 1)) begin
          state_next = VRF_IDLE;
          busy_next  = 1'b0;
        end
      end
      VRF_IDLE: begin
        busy_next = 1'b0;
      end
      default: begin
        state_next = VRF_CLEAR;
        busy_next  = 1'b1;
      end
    endcase
  end

  // Reset only redirects the engine; memory changes solely through clear or accepted writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_ptr_reg] <= '0;
      end else if (wr_fire) begin
        for (int i = 0; i < BE_WIDTH; i++) begin
          if (wr_be[i]) begin
            mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
          end
        end
      end
    end
  end

  assign mem_word_a = mem[rd_addr_a];
  assign mem_word_b = mem[rd_addr_b];

  vrf_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .rd_fire  (rd_fire_a),
    .rd_addr  (rd_addr_a),
    .mem_word (mem_word_a),
    .wr_fire  (wr_fire),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .rd_data  (rd_data_a),
    .rd_valid (rd_valid_a)
  );

  vrf_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .rd_fire  (rd_fire_b),
    .rd_addr  (rd_addr_b),
    .mem_word (mem_word_b),
    .wr_fire  (wr_fire),
    .wr_addr  (wr_addr),
    .wr_be    (wr_be),
    .wr_data  (wr_data),
    .rd_data  (rd_data_b),
    .rd_valid (rd_valid_b)
  );

  assign busy = busy_reg;

endmodule
